gray_rx_monitor: RTL
====================

# gray_rx_monitor

Downstream consumer of the free-running Gray-code counter. Synchronizes the counter's `gray_c` bus into the local clock domain, decodes it to binary and checks that every observed change is a legal +1 step (mod 2^CBITS). Reports per-step errors, wrap-around events and a fault state for the status block that sits after it.

## Interface
Parameters:
- CBITS, 15, width of the Gray bus and of the decoded value.
- SYNC_STAGES, 2, flops in the input synchronizer chain; legal range 2..4.
- ERR_LIMIT, 3, consecutive step errors that force FAULT; legal range 1..15.

Ports:
- clk  input  1  single clock; all state on posedge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- gray_in  input  CBITS  Gray count from the upstream counter.
- clr_err  input  1  clears `err_sticky`; in FAULT also restarts tracking.
- bin_out  output  CBITS  decoded binary value of the last accepted sample.
- bin_vld  output  1  high while `bin_out` is trustworthy (TRACK state).
- step_err  output  1  one-cycle pulse per illegal step.
- err_sticky  output  1  set by any `step_err`, held until `clr_err`.
- zero_pulse  output  1  one-cycle pulse when an accepted +1 step lands on 0 (wrap).
- wrap_cnt  output  8  wrap counter; present only with `GRAY_RX_WRAP_CNT_EN`.

## Operation
- Sync chain: SYNC_STAGES flops on `gray_in`, all reset to 0. `gs` denotes the last stage.
- Decode: `b[CBITS-1]=gs[CBITS-1]`, `b[i]=b[i+1]^gs[i]`. Compare with the registered previous value `ref`.
- Step delta: `d = (b - ref) mod 2^CBITS`.
  - d=0 is a hold: no action.
  - d=1 is an advance: accept it.
  - Any other value is a step error.
- FSM states: INIT, TRACK, FAULT. Reset state is INIT.
- INIT:
  - A fill counter counts SYNC_STAGES cycles.
  - On the cycle it expires, `ref<=b` and `bin_out<=b`, then go to TRACK.
  - No checks run in INIT.
- TRACK, hold: nothing changes.
- TRACK, advance:
  - `ref<=b`, `bin_out<=b`, and the consecutive-error counter clears.
  - If b==0, `zero_pulse` fires.
- TRACK, error:
  - `step_err` pulses and `err_sticky<=1`.
  - `ref<=b` (resync) and `bin_out<=b`.
  - The consecutive-error counter increments. When it reaches ERR_LIMIT, go to FAULT.
- FAULT:
  - `bin_vld=0` and no checks run. `bin_out` holds its last value.
  - `clr_err` moves to INIT and clears the error counter.
- `err_sticky`:
  - `clr_err` clears it in any state.
  - If a set and a clear occur in the same cycle, the set wins.
- `bin_vld`: 1 only in TRACK, combinational from state.

## Timing
- Reset values: `bin_out=0`, `bin_vld=0`, `step_err=0`, `err_sticky=0`, `zero_pulse=0`, `wrap_cnt=0`, FSM=INIT, sync chain=0.
- Latency: a change on `gray_in` appears on `bin_out` SYNC_STAGES+1 cycles later. `step_err` and `zero_pulse` are in the same cycle as the corresponding `bin_out` update.
- After `rst` deasserts: `bin_vld` rises SYNC_STAGES+1 cycles later (fill, then state update).
- Wrap: all-ones→0 is a legal advance; `zero_pulse=1`.
- A reverse step (d = 2^CBITS−1) is an error.
- A multi-bit Gray jump is an error; its decoded value still becomes `ref`.
- `rst` mid-operation returns every register to its reset value asynchronously, whatever the state.
- `clr_err` in INIT or TRACK clears only `err_sticky`; the state is unchanged.

## Configuration
- `GRAY_RX_WRAP_CNT_EN` defined:
  - `wrap_cnt` port exists.
  - An 8-bit counter increments on every `zero_pulse` and wraps 255→0.
  - `clr_err` does not clear it; only `rst` does.
- Not defined:
  - No `wrap_cnt` port and no counter logic.
  - All other behaviour is identical.

## Test plan
All scenarios use CBITS=4, SYNC_STAGES=2, ERR_LIMIT=3.
- Reset release, then `gray_in` held at 0000: `bin_vld` rises on cycle 3, `bin_out=0`, `step_err` never fires.
- Legal Gray sequence 0..15 then 0, one step per 4 cycles: `bin_out` tracks 0..15 with latency 3. Exactly one `zero_pulse`, at the 15→0 step. `wrap_cnt=1` with the macro.
- In TRACK at 5 (Gray 0111), drive Gray of 9 (1101): one `step_err` pulse, `err_sticky=1`, `bin_out=9`, still TRACK. The next +1 to 10 is accepted.
- Three consecutive illegal jumps (5→9→2→12): FAULT after the third, `bin_vld=0`. `clr_err` moves to INIT, and `bin_vld` rises 3 cycles later.
- Step error and `clr_err` in the same cycle: `err_sticky` stays 1. `clr_err` alone the next cycle clears it.
- Assert `rst` while in TRACK at value 7: all outputs drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gray_rx_monitor.sv
// Gray-code receive monitor: synchronizes a Gray count, decodes it and flags illegal steps.
// Optional wrap counter output is enabled by defining GRAY_RX_WRAP_CNT_EN.
module gray_rx_monitor #(
  parameter int unsigned CBITS       = 15,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_LIMIT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             clr_err,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_vld,
  output logic             step_err,
  output logic             err_sticky,
  output logic             zero_pulse
`ifdef GRAY_RX_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  state_t           state;
  logic [CBITS-1:0] sync_q [SYNC_STAGES];
  logic [CBITS-1:0] gs;
  logic [CBITS-1:0] b;
  logic [CBITS-1:0] ref_val;
  logic [CBITS-1:0] delta;
  logic [2:0]       fill_cnt;
  logic [3:0]       err_cnt;
  logic             is_hold;
  logic             is_adv;
  logic             wrap_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Binary bit i is the XOR of all Gray bits at and above i.
  always_comb begin
    gs = sync_q[SYNC_STAGES-1];
    b  = '0;
    for (int unsigned i = 0; i < CBITS; i++) b[i] = ^(gs >> i);
    delta    = b - ref_val;
    is_hold  = (delta == '0);
    is_adv   = (delta == CBITS'(1));
    wrap_hit = (state == TRACK) && is_adv && (b == '0);
  end

  assign bin_vld = (state == TRACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      fill_cnt   <= '0;
      err_cnt    <= '0;
      ref_val    <= '0;
      bin_out    <= '0;
      step_err   <= 1'b0;
      zero_pulse <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step_err   <= 1'b0;
      zero_pulse <= 1'b0;
      // A set in the TRACK error branch below overrides this clear.
      if (clr_err) err_sticky <= 1'b0;
      case (state)
        INIT: begin
          if (fill_cnt == 3'(SYNC_STAGES)) begin
            ref_val  <= b;
            bin_out  <= b;
            fill_cnt <= '0;
            state    <= TRACK;
          end else begin
            fill_cnt <= fill_cnt + 3'd1;
          end
        end
        TRACK: begin
          if (is_adv) begin
            ref_val    <= b;
            bin_out    <= b;
            err_cnt    <= '0;
            zero_pulse <= wrap_hit;
          end else if (!is_hold) begin
            step_err   <= 1'b1;
            err_sticky <= 1'b1;
            ref_val    <= b;
            bin_out    <= b;
            err_cnt    <= err_cnt + 4'd1;
            if (err_cnt + 4'd1 == 4'(ERR_LIMIT)) state <= FAULT;
          end
        end
        FAULT: begin
          if (clr_err) begin
            state    <= INIT;
            err_cnt  <= '0;
            fill_cnt <= '0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef GRAY_RX_WRAP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_cnt <= '0;
    else if (wrap_hit) wrap_cnt <= wrap_cnt + 8'd1;
  end
`endif

endmodule
